// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC -> imem request -> IF/ID register, next-PC feedback. IFU_MISALIGN_TRAP_EN enables misaligned-redirect trap.
// Latency: IF/ID loads on the edge that samples imem_ack_i; one instruction/cycle with zero-wait memory.
// Backpressure: stall_i parks an acked word in a one-entry skid buffer and holds the PC until ID accepts it.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ack_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        misalign_o
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc4;

  assign pc4          = pc_i + 32'd4;
  assign imem_addr_o  = pc_i;
  assign imem_req_o   = rst_i && (state_q == FETCH);
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`else
  logic [31:0] trap_vector_unused;
  assign trap_vector_unused = TRAP_VECTOR;
`endif

  always_comb begin
    state_d      = state_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_vld_d   = skid_vld_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    pc_next_o    = pc_i;
`ifdef IFU_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    if (redirect_i) begin
      // Flush wins over everything, including a word acked this same cycle.
      pc_next_o    = redirect_pc_i;
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        pc_next_o  = TRAP_VECTOR;
        misalign_d = 1'b1;
      end
`endif
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
      skid_vld_d   = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack_i) begin
            pc_next_o = pc4;
            if (stall_i) begin
              skid_instr_d = imem_rdata_i;
              skid_pc4_d   = pc4;
              skid_vld_d   = 1'b1;
              state_d      = HOLD;
            end else begin
              ifid_instr_d = imem_rdata_i;
              ifid_pc4_d   = pc4;
              ifid_valid_d = 1'b1;
            end
          end else if (!stall_i) begin
            ifid_instr_d = NOP_WORD;
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_instr_d = skid_instr_q;
            ifid_pc4_d   = skid_pc4_q;
            ifid_valid_d = skid_vld_q;
            skid_vld_d   = 1'b0;
            state_d      = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= FETCH;
      skid_instr_q <= NOP_WORD;
      skid_pc4_q   <= 32'd0;
      skid_vld_q   <= 1'b0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_vld_q   <= skid_vld_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule
